// File: rtl/round_controller.sv
// round_controller
//   Sequencing controller for the shared round adder in the add/sub path.
//   It accepts a normalized mantissa, exponent and guard/round/sticky bits,
//   decides round-to-nearest-even, drives the external combinational round
//   adder for one cycle, renormalizes on carry-out and presents the result
//   with an exponent-overflow (infinity) flag.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   in_valid/ready  : operand handshake; in_ready only in IDLE and out of reset
//   in_sign/exp/mant/grs : operand fields, grs = {guard, round, sticky}
//   ra_data/ra_round     : drive the round adder (InData, round)
//   ra_result/ra_overflow: round adder RoundedData and carry-out
//   out_valid/ready : result handshake
//   out_sign/exp/mant/exp_ovf : rounded result, exp_ovf marks infinity
module round_controller #(
  parameter int MANT_W = 8,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [2:0]        in_grs,
  output logic [MANT_W-1:0] ra_data,
  output logic              ra_round,
  input  logic [MANT_W-1:0] ra_result,
  input  logic              ra_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_exp_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    NORM,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              sign_q,  sign_d;
  logic [EXP_W-1:0]  exp_q,   exp_d;
  logic [MANT_W-1:0] mant_q,  mant_d;
  logic [2:0]        grs_q,   grs_d;
  logic              cy_q,    cy_d;
  logic              ovf_q,   ovf_d;

  logic              rne_inc;
  logic [EXP_W-1:0]  exp_inc;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    grs_d    = grs_q;
    cy_d     = cy_q;
    ovf_d    = ovf_q;
    ra_round = 1'b0;

    // Round up when above half, or exactly half with an odd LSB (ties to even).
    rne_inc  = grs_q[2] & (grs_q[1] | grs_q[0] | mant_q[0]);
    exp_inc  = exp_q + EXP_W'(1);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d = in_sign;
          exp_d  = in_exp;
          mant_d = in_mant;
          grs_d  = in_grs;
          cy_d   = 1'b0;
          ovf_d  = 1'b0;
          // All-ones exponent is inf/NaN: pass straight through unrounded.
          state_d = (&in_exp) ? DONE : ROUND;
        end
      end
      ROUND: begin
        ra_round = rne_inc;
        mant_d   = ra_result;
        cy_d     = ra_overflow;
        state_d  = ra_overflow ? NORM : DONE;
      end
      NORM: begin
        exp_d = exp_inc;
        if (&exp_inc) begin
          ovf_d  = 1'b1;
          mant_d = '0;
        end else begin
          // cy_q is always set here; shifting it in yields 100..0.
          mant_d = {cy_q, mant_q[MANT_W-1:1]};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      grs_q   <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      grs_q   <= grs_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE) & ~rst;
  assign ra_data     = mant_q;
  assign out_valid   = (state_q == DONE);
  assign out_sign    = sign_q;
  assign out_exp     = exp_q;
  assign out_mant    = mant_q;
  assign out_exp_ovf = ovf_q;

endmodule

// File: tb/tb_round_controller.sv
module tb_round_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [7:0] in_exp;
  logic [7:0] in_mant;
  logic [2:0] in_grs;
  logic [7:0] ra_data;
  logic       ra_round;
  logic [7:0] ra_result;
  logic       ra_overflow;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [7:0] out_exp;
  logic [7:0] out_mant;
  logic       out_exp_ovf;

  round_controller #(.MANT_W(8), .EXP_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
    .ra_data(ra_data), .ra_round(ra_round),
    .ra_result(ra_result), .ra_overflow(ra_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
    .out_exp_ovf(out_exp_ovf)
  );

  always #5 clk = ~clk;

  // External combinational round adder.
  logic [8:0] ra_sum;
  assign ra_sum = {1'b0, ra_data} + {8'd0, ra_round};
  assign ra_result   = ra_sum[7:0];
  assign ra_overflow = ra_sum[8];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [7:0] mant;
    logic       ovf;
  } res_t;

  res_t sbq[$];

  // Scoreboard: compare every consumed result with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("stale_result", 32'(out_mant), 32'hdead);
      end else begin
        res_t e;
        e = sbq.pop_front();
        chk("out_sign", 32'(out_sign), 32'(e.sign));
        chk("out_exp", 32'(out_exp), 32'(e.exp));
        chk("out_mant", 32'(out_mant), 32'(e.mant));
        chk("out_exp_ovf", 32'(out_exp_ovf), 32'(e.ovf));
      end
    end
  end

  typedef struct {
    logic       sign;
    logic [7:0] exp;
    logic [7:0] mant;
    logic [2:0] grs;
    logic [7:0] e_exp;
    logic [7:0] e_mant;
    logic       e_ovf;
    int         lat;
    logic       e_rnd;
    int         hold;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // sign exp mant grs | exp mant ovf latency ra_round hold
    vecs[0]  = '{1'b1, 8'h10, 8'hFF, 3'b000, 8'h10, 8'hFF, 1'b0, 2, 1'b0, 0};
    vecs[1]  = '{1'b0, 8'h10, 8'hFF, 3'b100, 8'h11, 8'h80, 1'b0, 3, 1'b1, 0};
    vecs[2]  = '{1'b0, 8'h20, 8'h0B, 3'b110, 8'h20, 8'h0C, 1'b0, 2, 1'b1, 5};
    vecs[3]  = '{1'b1, 8'h20, 8'h0A, 3'b100, 8'h20, 8'h0A, 1'b0, 2, 1'b0, 0};
    vecs[4]  = '{1'b0, 8'h20, 8'h0A, 3'b101, 8'h20, 8'h0B, 1'b0, 2, 1'b1, 0};
    vecs[5]  = '{1'b0, 8'hFE, 8'hFF, 3'b110, 8'hFF, 8'h00, 1'b1, 3, 1'b1, 0};
    vecs[6]  = '{1'b1, 8'hFF, 8'h40, 3'b111, 8'hFF, 8'h40, 1'b0, 1, 1'b0, 0};
    vecs[7]  = '{1'b0, 8'h01, 8'h7F, 3'b011, 8'h01, 8'h7F, 1'b0, 2, 1'b0, 0};
    vecs[8]  = '{1'b0, 8'h05, 8'hFE, 3'b100, 8'h05, 8'hFE, 1'b0, 2, 1'b0, 0};
    vecs[9]  = '{1'b1, 8'h05, 8'hFE, 3'b111, 8'h05, 8'hFF, 1'b0, 2, 1'b1, 0};
    vecs[10] = '{1'b0, 8'h00, 8'hFF, 3'b101, 8'h01, 8'h80, 1'b0, 3, 1'b1, 0};

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_grs = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_mant", 32'(out_mant), 0);
    chk("rst_out_exp", 32'(out_exp), 0);
    chk("rst_out_sign", 32'(out_sign), 0);
    chk("rst_out_ovf", 32'(out_exp_ovf), 0);
    chk("rst_ra_round", 32'(ra_round), 0);
    chk("rst_ra_data", 32'(ra_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 11; i++) begin
      int   n;
      logic rnd_seen;
      @(posedge clk); #1;
      in_valid = 1'b1; in_sign = vecs[i].sign; in_exp = vecs[i].exp;
      in_mant = vecs[i].mant; in_grs = vecs[i].grs;
      @(negedge clk);
      chk("accept_ready", 32'(in_ready), 1);
      sbq.push_back('{vecs[i].sign, vecs[i].e_exp, vecs[i].e_mant, vecs[i].e_ovf});
      @(posedge clk); #1 in_valid = 1'b0;
      n = 0; rnd_seen = 1'b0;
      while (n < 8) begin
        @(negedge clk);
        n++;
        rnd_seen = rnd_seen | ra_round;
        if (out_valid) break;
      end
      chk("latency", 32'(n), 32'(vecs[i].lat));
      chk("ra_round_seen", 32'(rnd_seen), 32'(vecs[i].e_rnd));
      if (!out_valid) begin
        // Recover from a stuck controller so the rest of the run continues.
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        sbq.delete();
        continue;
      end
      for (int h = 0; h < vecs[i].hold; h++) begin
        @(posedge clk); #1;
        in_valid = 1'b1; in_exp = 8'h33; in_mant = 8'h55; in_grs = 3'b111;
        @(negedge clk);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_mant", 32'(out_mant), 32'(vecs[i].e_mant));
        chk("bp_out_exp", 32'(out_exp), 32'(vecs[i].e_exp));
      end
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      chk("post_in_ready", 32'(in_ready), 1);
      chk("post_out_valid", 32'(out_valid), 0);
    end

    // Reset during ROUND: the in-flight result must vanish.
    @(posedge clk); #1;
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h20; in_mant = 8'h0B; in_grs = 3'b110;
    @(negedge clk);
    chk("rstop_accept", 32'(in_ready), 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rstop_in_round", 32'(ra_round), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstop_in_ready_low", 32'(in_ready), 0);
    chk("rstop_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstop_in_ready_high", 32'(in_ready), 1);
    chk("rstop_out_mant", 32'(out_mant), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstop_no_result", 32'(out_valid), 0);
    end
    out_ready = 1'b0;

    chk("sb_drained", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
